// File: rtl/encap_head_ins.sv
`default_nettype none
// encap_head_ins: prepends 0..MAX_INS encapsulation slices per packet and realigns the metadata stream.
// Rev 1.0 -- optional metadata shift window built when ENCAP_META_SHIFT_EN is defined.
module encap_head_ins #(
    parameter int HEAD_W     = 512,
    parameter int TAG_W      = 3,
    parameter int MAX_INS    = 4,
    parameter int META_W     = 128,
    parameter int SHIFT_UNIT = 16,
    parameter int CNT_W      = $clog2(MAX_INS + 1),
    parameter int MSH_W      = $clog2(META_W / SHIFT_UNIT)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [HEAD_W+TAG_W-1:0]     i_head,
    output logic                        o_head_ready,
    input  logic [CNT_W-1:0]            i_ins_cnt,
    input  logic [MAX_INS*HEAD_W-1:0]   i_ins_data,
    output logic [HEAD_W+TAG_W-1:0]     o_head,
    output logic                        o_err_drop,
    input  logic [META_W+TAG_W-1:0]     i_meta,
    input  logic [MSH_W-1:0]            i_meta_shift,
    output logic [META_W+TAG_W-1:0]     o_meta
);

    localparam int SLICE_W = HEAD_W + TAG_W;
    localparam logic [TAG_W-1:0] TAG_V  = TAG_W'(1);
    localparam logic [TAG_W-1:0] TAG_VS = TAG_W'(3);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INSERT = 2'd1,
        PASS   = 2'd2
    } state_t;

    state_t                      state, state_nxt;
    logic [SLICE_W-1:0]          hold, hold_nxt, hold_out;
    logic [MAX_INS*HEAD_W-1:0]   ins_buf, ins_buf_nxt;
    logic [CNT_W-1:0]            rem, rem_nxt, n_ins;
    logic [SLICE_W-1:0]          head_nxt;
    logic                        ready_nxt, err_nxt;
    logic                        head_acc, head_start, head_tail;

    assign head_acc   = i_head[HEAD_W] & o_head_ready;
    assign head_start = i_head[HEAD_W+1];
    assign head_tail  = i_head[HEAD_W+2];
    assign n_ins      = (i_ins_cnt > CNT_W'(MAX_INS)) ? CNT_W'(MAX_INS) : i_ins_cnt;
    // Held original leaves with start cleared; tail and valid are kept.
    assign hold_out   = {hold[SLICE_W-1:HEAD_W+2], 1'b0, hold[HEAD_W:0]};

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold;
        ins_buf_nxt = ins_buf;
        rem_nxt     = rem;
        head_nxt    = '0;
        ready_nxt   = 1'b1;
        err_nxt     = 1'b0;
        case (state)
            INSERT: begin
                if (rem != '0) begin
                    head_nxt    = {TAG_V, ins_buf[HEAD_W-1:0]};
                    ins_buf_nxt = ins_buf >> HEAD_W;
                    rem_nxt     = rem - CNT_W'(1);
                    ready_nxt   = 1'b0;
                end else begin
                    head_nxt  = hold_out;
                    state_nxt = hold[HEAD_W+2] ? IDLE : PASS;
                end
            end
            default: begin
                if (head_acc) begin
                    if (head_start) begin
                        // A start while in PASS closes the previous packet implicitly.
                        err_nxt = (state == PASS);
                        if (n_ins == '0) begin
                            head_nxt  = i_head;
                            state_nxt = head_tail ? IDLE : PASS;
                        end else begin
                            head_nxt    = {TAG_VS, i_ins_data[HEAD_W-1:0]};
                            hold_nxt    = i_head;
                            ins_buf_nxt = i_ins_data >> HEAD_W;
                            rem_nxt     = n_ins - CNT_W'(1);
                            ready_nxt   = 1'b0;
                            state_nxt   = INSERT;
                        end
                    end else if (state == PASS) begin
                        head_nxt = i_head;
                        if (head_tail) begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            hold         <= '0;
            ins_buf      <= '0;
            rem          <= '0;
            o_head       <= '0;
            o_head_ready <= 1'b0;
            o_err_drop   <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold         <= hold_nxt;
            ins_buf      <= ins_buf_nxt;
            rem          <= rem_nxt;
            o_head       <= head_nxt;
            o_head_ready <= ready_nxt;
            o_err_drop   <= err_nxt;
        end
    end

`ifdef ENCAP_META_SHIFT_EN
    localparam int STEPS = META_W / SHIFT_UNIT;

    logic                  meta_start;
    logic [MSH_W-1:0]      shift_r, shift_now;
    logic [META_W-1:0]     prev, prev_now;
    logic [2*META_W-1:0]   window, window_sh;
    logic                  unused_win;

    assign meta_start = i_meta[META_W+1];
    assign shift_now  = !meta_start ? shift_r :
                        (int'(i_meta_shift) > STEPS - 1) ? MSH_W'(STEPS - 1) : i_meta_shift;
    assign prev_now   = meta_start ? '0 : prev;
    assign window     = {prev_now, i_meta[META_W-1:0]};
    // Selecting window[2W-1-s*U -: W] is a right shift by W - s*U.
    assign window_sh  = window >> (META_W - int'(shift_now) * SHIFT_UNIT);
    assign unused_win = ^window_sh[2*META_W-1:META_W];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_meta  <= '0;
            shift_r <= '0;
            prev    <= '0;
        end else if (i_meta[META_W]) begin
            o_meta  <= {i_meta[META_W+TAG_W-1:META_W], window_sh[META_W-1:0]};
            shift_r <= shift_now;
            prev    <= i_meta[META_W-1:0];
        end else begin
            o_meta  <= '0;
        end
    end
`else
    logic unused_shift;
    assign unused_shift = ^i_meta_shift;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_meta <= '0;
        end else begin
            o_meta <= i_meta;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_encap_head_ins.sv
`default_nettype none
// tb_encap_head_ins: randomized scoreboard bench for encap_head_ins (head insert path and metadata path).
module tb_encap_head_ins;

    localparam int HW  = 512;
    localparam int TW  = 3;
    localparam int MI  = 4;
    localparam int MW  = 128;
    localparam int SU  = 16;
    localparam int CW  = 3;
    localparam int MSW = 3;
    localparam int STEPS = MW / SU;

    logic                 clk = 1'b0;
    logic                 i_rst_n;
    logic [HW+TW-1:0]     i_head;
    logic                 o_head_ready;
    logic [CW-1:0]        i_ins_cnt;
    logic [MI*HW-1:0]     i_ins_data;
    logic [HW+TW-1:0]     o_head;
    logic                 o_err_drop;
    logic [MW+TW-1:0]     i_meta;
    logic [MSW-1:0]       i_meta_shift;
    logic [MW+TW-1:0]     o_meta;

    always #5 clk = ~clk;

    encap_head_ins dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_head       (i_head),
        .o_head_ready (o_head_ready),
        .i_ins_cnt    (i_ins_cnt),
        .i_ins_data   (i_ins_data),
        .o_head       (o_head),
        .o_err_drop   (o_err_drop),
        .i_meta       (i_meta),
        .i_meta_shift (i_meta_shift),
        .o_meta       (o_meta)
    );

    typedef struct {
        int               cyc;
        logic [HW+TW-1:0] d;
    } hexp_t;

    hexp_t            hq[$];
    int               eq[$];
    logic [MW+TW-1:0] mq[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic rst_seen = 1'b0;
    bit   in_pkt = 1'b0;
    int   stall_lo = 0;
    int   stall_hi = -1;
    int   m_s = 0;
    logic [MW-1:0] m_prev = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= i_rst_n;
    end

    task automatic chk(input string nm, input logic [HW+TW-1:0] act, input logic [HW+TW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [HW-1:0] rnd_head();
        logic [HW-1:0] r;
        for (int k = 0; k < HW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Packet-level reference: what each accepted slice must produce and when.
    task automatic accept_model(input logic [HW+TW-1:0] s, input int cnt, input logic [MI*HW-1:0] ins);
        int   n;
        logic st, tl;
        st = s[HW+1];
        tl = s[HW+2];
        if (st) begin
            if (in_pkt) eq.push_back(cyc + 1);
            n = (cnt > MI) ? MI : cnt;
            if (n == 0) begin
                hq.push_back('{cyc + 1, s});
            end else begin
                for (int j = 0; j < n; j++)
                    hq.push_back('{cyc + 1 + j, {((j == 0) ? 3'b011 : 3'b001), ins[j*HW +: HW]}});
                hq.push_back('{cyc + n + 1, {tl, 1'b0, 1'b1, s[HW-1:0]}});
                stall_lo = cyc + 1;
                stall_hi = cyc + n;
            end
            in_pkt = !tl;
        end else if (!in_pkt) begin
            eq.push_back(cyc + 1);
        end else begin
            hq.push_back('{cyc + 1, s});
            if (tl) in_pkt = 1'b0;
        end
    endtask

    task automatic send_slice(input logic [2:0] tg, input int cnt);
        logic [HW-1:0]    d;
        logic [MI*HW-1:0] ins;
        int               w;
        d = rnd_head();
        for (int k = 0; k < MI; k++) ins[k*HW +: HW] = rnd_head();
        w = 0;
        forever begin
            @(negedge clk);
            i_head     = {tg, d};
            i_ins_cnt  = CW'(cnt);
            i_ins_data = ins;
            if (o_head_ready) begin
                accept_model({tg, d}, cnt, ins);
                break;
            end
            w++;
            if (w > 40) begin
                total++;
                bad++;
                $display("FAIL accept_timeout cyc=%0d got=ready_low want=ready_high", cyc);
                break;
            end
        end
    endtask

    task automatic bubble(input int n);
        repeat (n) begin
            @(negedge clk);
            i_head    = {3'b110, rnd_head()};
            i_ins_cnt = CW'($urandom_range(0, 7));
        end
    endtask

    task automatic send_pkt(input int len, input int cnt, input bit notail);
        for (int i = 0; i < len; i++) begin
            send_slice({(i == len - 1) && !notail, i == 0, 1'b1}, (i == 0) ? cnt : 0);
            if ($urandom_range(0, 3) == 0) bubble($urandom_range(1, 2));
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        i_rst_n = 1'b0;
        i_head  = '0;
        repeat (n) @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    // Head monitor: ready, error pulse and emitted slices against the scoreboard.
    always @(negedge clk) begin : head_mon
        logic  exp_rdy, exp_err;
        hexp_t e;
        if (cyc > 0) begin
            if (!rst_seen) begin
                hq.delete();
                eq.delete();
                stall_lo = 0;
                stall_hi = -1;
                in_pkt   = 1'b0;
                chk("rst_head", o_head, '0);
                chk("rst_ready", {514'd0, o_head_ready}, '0);
                chk("rst_err", {514'd0, o_err_drop}, '0);
            end else begin
                exp_rdy = !(cyc >= stall_lo && cyc <= stall_hi);
                chk("ready", {514'd0, o_head_ready}, {514'd0, exp_rdy});
                exp_err = 1'b0;
                if (eq.size() > 0 && eq[0] == cyc) begin
                    exp_err = 1'b1;
                    void'(eq.pop_front());
                end
                chk("err_drop", {514'd0, o_err_drop}, {514'd0, exp_err});
                while (hq.size() > 0 && hq[0].cyc < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL head_missing cyc=%0d got=none want_at=%0d", cyc, hq[0].cyc);
                    void'(hq.pop_front());
                end
                if (hq.size() > 0 && hq[0].cyc == cyc) begin
                    e = hq.pop_front();
                    chk("head", o_head, e.d);
                end else begin
                    chk("head_idle", o_head, '0);
                end
            end
        end
    end

    // Metadata stimulus and scoreboard: expected value pushed at drive, popped one cycle later.
    initial begin : meta_proc
        int               left;
        logic [MW+TW-1:0] e;
        logic [MW-1:0]    d;
        logic             st, tl;
        logic [2:0]       tg;
        int               sh;
        logic [2*MW-1:0]  win;
        left         = 0;
        i_meta       = '0;
        i_meta_shift = '0;
        forever begin
            @(negedge clk);
            if (!rst_seen) begin
                m_prev = '0;
                m_s    = 0;
            end
            if (mq.size() > 0) begin
                e = mq.pop_front();
                if (!rst_seen) e = '0;
                chk("meta", {384'd0, o_meta}, {384'd0, e});
            end
            if ($urandom_range(0, 3) == 0) begin
                i_meta       = '0;
                i_meta_shift = MSW'($urandom_range(0, 7));
                e            = '0;
            end else begin
                d  = {$urandom, $urandom, $urandom, $urandom};
                st = (left == 0);
                if (st) left = $urandom_range(1, 4);
                tl = (left == 1);
                left--;
                tg = {tl, st, 1'b1};
                sh = $urandom_range(0, 7);
                i_meta       = {tg, d};
                i_meta_shift = MSW'(sh);
`ifdef ENCAP_META_SHIFT_EN
                if (st) begin
                    m_s    = (sh > STEPS - 1) ? STEPS - 1 : sh;
                    m_prev = '0;
                end
                win    = {m_prev, d};
                e      = {tg, win[2*MW-1-m_s*SU -: MW]};
                m_prev = d;
`else
                win = '0;
                e   = {tg, d};
`endif
            end
            mq.push_back(e);
        end
    end

    initial begin
        i_rst_n    = 1'b0;
        i_head     = '0;
        i_ins_cnt  = '0;
        i_ins_data = '0;
        repeat (4) @(negedge clk);
        i_rst_n = 1'b1;
        bubble(2);
        // pass-through, insert-2, clamped single-slice insert
        send_pkt(3, 0, 1'b0);
        bubble(2);
        send_pkt(2, 2, 1'b0);
        send_slice(3'b111, 7);
        bubble(1);
        // stray non-start slices in IDLE
        send_slice(3'b001, 0);
        send_slice(3'b101, 0);
        // start arriving in PASS
        send_slice(3'b011, 0);
        send_slice(3'b001, 0);
        send_slice(3'b011, 1);
        send_slice(3'b101, 0);
        // reset in the middle of a 3-slice insert
        send_slice(3'b011, 3);
        do_reset(2);
        send_pkt(2, 1, 1'b0);
        send_slice(3'b111, 0);
        for (int p = 0; p < 80; p++) begin
            if ($urandom_range(0, 9) == 0) send_slice(3'b001, 0);
            send_pkt($urandom_range(1, 4), $urandom_range(0, 7), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) bubble($urandom_range(1, 3));
        end
        bubble(8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
